mult_div_unit: RTL and testbench

- Iterative multiply/divide unit that sits directly downstream of the register file.
- Consumes the two register read buses (rs, rt) and owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Asserts busy so the control path can stall the PC while an operation is in flight.
- HI/LO feed the write-back mux for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative shift-add multiplier / restoring divider owning HI/LO.
// Revision : 1.0
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             start,
    input  logic [2:0]       mdop,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_hi, r_lo, r_opd;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_q, r_neg_r, r_is_div, r_done;

    logic               w_accept, w_op_mul, w_op_div, w_op_mthi, w_op_mtlo;
    logic               w_signed, w_a_neg, w_b_neg, w_b_zero, w_last;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_mul_sum, w_div_shift, w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    assign w_accept  = start && (r_state == S_IDLE);
    assign w_op_mul  = (mdop[2:1] == 2'b00);
    assign w_op_div  = (mdop[2:1] == 2'b01);
    assign w_op_mthi = (mdop == 3'b100);
    assign w_op_mtlo = (mdop == 3'b101);
    assign w_signed  = ~mdop[0];
    assign w_a_neg   = w_signed & OpA[WIDTH-1];
    assign w_b_neg   = w_signed & OpB[WIDTH-1];
    assign w_b_zero  = (OpB == '0);
    // Negating 0x80000000 yields the same pattern, read as unsigned 2^31.
    assign w_mag_a   = w_a_neg ? -OpA : OpA;
    assign w_mag_b   = w_b_neg ? -OpB : OpB;
    assign w_last    = (r_cnt == CW'(ITER - 1));

    // Multiply: multiplier in r_acc low half, product grows from the top.
    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    // Divide: r_acc = {partial remainder, dividend/quotient shift register}.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opd});
    assign w_div_diff  = w_div_shift - {1'b0, r_opd};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_op_mul)                   w_next = S_MUL;
                else if (w_accept && w_op_div && !w_b_zero) w_next = S_DIV;
            end
            S_MUL:   if (w_last) w_next = S_FIX;
            S_DIV:   if (w_last) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_op_mthi) r_hi <= OpA;
                        if (w_op_mtlo) r_lo <= OpA;
                        if (w_op_mul) begin
                            r_opd    <= w_mag_a;
                            r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= 1'b0;
                            r_is_div <= 1'b0;
                            r_cnt    <= '0;
                        end
                        if (w_op_div && w_b_zero) begin
                            r_hi   <= OpA;
                            r_lo   <= '1;
                            r_done <= 1'b1;
                        end
                        if (w_op_div && !w_b_zero) begin
                            r_opd    <= w_mag_b;
                            r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_is_div <= 1'b1;
                            r_cnt    <= '0;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_DIV: begin
                    r_acc <= {w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0],
                              r_acc[WIDTH-2:0], w_div_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Directed bench with a cycle-level arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_mult_div_unit;

    logic        CLK   = 1'b0;
    logic        RST_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mdop  = 3'd0;
    logic [31:0] OpA   = '0;
    logic [31:0] OpB   = '0;
    logic [31:0] HI, LO;
    logic        busy, done;

    int n_chk  = 0;
    int n_pass = 0;
    bit en     = 1'b0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .mdop(mdop),
        .OpA(OpA), .OpB(OpB), .HI(HI), .LO(LO), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endfunction

    // Reference model: a 33-edge countdown plus plain arithmetic on wide integers.
    logic [31:0]        m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int                 m_cnt = 0;
    bit                 m_done = 1'b0;
    logic signed [63:0] sa, sb, t;

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            m_hi = '0; m_lo = '0; m_cnt = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (start) begin
                if (mdop[0]) begin
                    sa = {32'b0, OpA}; sb = {32'b0, OpB};
                end else begin
                    sa = {{32{OpA[31]}}, OpA}; sb = {{32{OpB[31]}}, OpB};
                end
                case (mdop)
                    3'd0, 3'd1: begin
                        t = sa * sb;
                        p_hi = t[63:32]; p_lo = t[31:0]; m_cnt = 33;
                    end
                    3'd2, 3'd3: begin
                        if (OpB == 0) begin
                            m_hi = OpA; m_lo = 32'hFFFFFFFF; m_done = 1'b1;
                        end else begin
                            t = sa / sb; p_lo = t[31:0];
                            t = sa % sb; p_hi = t[31:0];
                            m_cnt = 33;
                        end
                    end
                    3'd4:    m_hi = OpA;
                    3'd5:    m_lo = OpA;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge CLK) begin
        if (en) begin
            chk("model_hi",   HI, m_hi);
            chk("model_lo",   LO, m_lo);
            chk("model_busy", 32'(busy), 32'(m_cnt > 0));
            chk("model_done", 32'(done), 32'(m_done));
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        start = 1'b1; mdop = op; OpA = a; OpB = b;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Waits for done, counting busy cycles seen on the way.
    task automatic wait_done(output int nb);
        int k;
        nb = 0; k = 0;
        while (!done && k < 80) begin
            if (busy) nb++;
            k++;
            @(negedge CLK);
        end
        n_chk++;
        if (done) n_pass++;
        else $display("FAIL wait_done: done=%b expected 1 within 80 cycles", done);
    endtask

    int nb;

    initial begin
        #1 RST_n = 1'b0;
        #1;
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        en = 1'b1;
        repeat (2) @(negedge CLK);
        #2 RST_n = 1'b1;

        // MULT -3 * 7
        issue(3'd0, 32'hFFFFFFFD, 32'd7);
        wait_done(nb);
        chk("mult_busy_cycles", 32'(nb), 32'd33);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFEB);
        @(negedge CLK);
        chk("mult_done_one_cycle", 32'(done), 32'h0);

        // MULTU same operands
        issue(3'd1, 32'hFFFFFFFD, 32'd7);
        wait_done(nb);
        chk("multu_hi", HI, 32'h00000006);
        chk("multu_lo", LO, 32'hFFFFFFEB);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_done(nb);
        chk("div_busy_cycles", 32'(nb), 32'd33);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);

        // DIVU 100 / 7
        issue(3'd3, 32'd100, 32'd7);
        wait_done(nb);
        chk("divu_busy_cycles", 32'(nb), 32'd33);
        chk("divu_lo", LO, 32'd14);
        chk("divu_hi", HI, 32'd2);

        // Divide by zero resolves at the accepting edge
        issue(3'd2, 32'h1234, 32'h0);
        chk("div0_done", 32'(done), 32'h1);
        chk("div0_busy", 32'(busy), 32'h0);
        chk("div0_hi", HI, 32'h1234);
        chk("div0_lo", LO, 32'hFFFFFFFF);
        @(negedge CLK);
        chk("div0_done_clear", 32'(done), 32'h0);

        // Most-negative / -1
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(nb);
        chk("divmin_lo", LO, 32'h80000000);
        chk("divmin_hi", HI, 32'h0);

        // Starts while busy are ignored
        issue(3'd4, 32'h1111, 32'h0);
        issue(3'd0, 32'd3, 32'd5);
        issue(3'd4, 32'hAAAA, 32'h0);
        issue(3'd0, 32'd9, 32'd9);
        chk("collide_hi_held", HI, 32'h1111);
        wait_done(nb);
        chk("collide_hi", HI, 32'h0);
        chk("collide_lo", LO, 32'd15);

        // Start held from E0: ignored at E33, accepted at E34
        @(negedge CLK);
        start = 1'b1; mdop = 3'd1; OpA = 32'd2; OpB = 32'd3;
        @(negedge CLK);
        OpA = 32'd4;
        wait_done(nb);
        chk("held_busy_cycles", 32'(nb), 32'd33);
        chk("held_lo1", LO, 32'd6);
        chk("held_busy_at_e33", 32'(busy), 32'h0);
        @(negedge CLK);
        chk("held_busy_at_e34", 32'(busy), 32'h1);
        start = 1'b0;
        wait_done(nb);
        chk("held_lo2", LO, 32'd12);
        chk("held_hi2", HI, 32'd0);

        // MTLO leaves HI alone and never raises busy/done
        issue(3'd4, 32'h99, 32'h0);
        issue(3'd5, 32'h55, 32'h0);
        chk("mtlo_lo", LO, 32'h55);
        chk("mtlo_hi", HI, 32'h99);
        chk("mtlo_busy", 32'(busy), 32'h0);
        chk("mtlo_done", 32'(done), 32'h0);

        // Asynchronous reset mid-multiply
        issue(3'd0, 32'h12345, 32'h6789);
        repeat (9) @(negedge CLK);
        #2 RST_n = 1'b0;
        #1;
        chk("arst_hi", HI, 32'h0);
        chk("arst_lo", LO, 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        @(negedge CLK);
        #2 RST_n = 1'b1;
        issue(3'd0, 32'hFFFFFFFD, 32'd7);
        wait_done(nb);
        chk("post_rst_hi", HI, 32'hFFFFFFFF);
        chk("post_rst_lo", LO, 32'hFFFFFFEB);
        repeat (2) @(negedge CLK);

        en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
